// File: rtl/axil_adder_core_if.sv
// AXI4-Lite register-bus bundle between a PS/VIP master and the adder slave.
interface axil_adder_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axil_adder_core.sv
// AXI4-Lite slave with OP_A/OP_B/CTRL/RESULT registers; a START write
// launches a pipelined 32-bit add that sets a sticky DONE flag and irq.
module axil_adder_core #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int ADD_LATENCY        = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axil_adder_core_if.slave    s_axi,
  output logic                irq
);

  localparam logic [1:0] REG_OPA  = 2'd0;
  localparam logic [1:0] REG_OPB  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_RES  = 2'd3;

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Control/status word as seen by a read.
  function automatic logic [31:0] ctrl_word(input logic irq_en, input logic busy,
                                            input logic done, input logic carry);
    return {21'd0, carry, done, busy, 6'd0, irq_en, 1'b0};
  endfunction

  logic        alive_q;
  logic        aw_held_q, aw_held_d;
  logic [1:0]  awidx_q, awidx_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        irq_en_q, irq_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        carry_q, carry_d;
  logic [31:0] result_q, result_d;

  logic [32:0]            sum_p [ADD_LATENCY];
  logic [ADD_LATENCY-1:0] vld_p;

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs;
  logic commit, wr_ctrl, start_go, w1c, finish;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // alive_q keeps every ready low through reset and its release edge.
  assign awready = alive_q & ~aw_held_q & ~bvalid_q;
  assign wready  = alive_q & ~w_held_q  & ~bvalid_q;
  assign arready = alive_q & ~rvalid_q;

  assign aw_hs = s_axi.S_AXI_AWVALID & awready;
  assign w_hs  = s_axi.S_AXI_WVALID  & wready;
  assign ar_hs = s_axi.S_AXI_ARVALID & arready;

  assign commit   = aw_held_q & w_held_q;
  assign wr_ctrl  = commit & (awidx_q == REG_CTRL);
  assign start_go = wr_ctrl & wstrb_q[0] & wdata_q[0] & ~busy_q;
  assign w1c      = wr_ctrl & wstrb_q[1] & wdata_q[9];
  assign finish   = vld_p[ADD_LATENCY-1];

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign irq                 = done_q & irq_en_q;

  // Next-state for the bus channels and the register file.
  always_comb begin
    aw_held_d = aw_held_q;
    awidx_d   = awidx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    irq_en_d  = irq_en_q;
    busy_d    = busy_q;
    done_d    = done_q;
    carry_d   = carry_q;
    result_d  = result_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axi.S_AXI_AWADDR[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end
    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (awidx_q)
        REG_OPA:  opa_d = apply_wstrb(opa_q, wdata_q, wstrb_q);
        REG_OPB:  opb_d = apply_wstrb(opb_q, wdata_q, wstrb_q);
        REG_CTRL: if (wstrb_q[0]) irq_en_d = wdata_q[1];
        default:  ;
      endcase
    end

    if (start_go) busy_d = 1'b1;
    if (w1c)      done_d = 1'b0;
    // Completion outranks a simultaneous W1C of DONE.
    if (finish) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = sum_p[ADD_LATENCY-1][31:0];
      carry_d  = sum_p[ADD_LATENCY-1][32];
    end

    // Reads return register state from before this edge's updates.
    if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (s_axi.S_AXI_ARADDR[3:2])
        REG_OPA:  rdata_d = opa_q;
        REG_OPB:  rdata_d = opb_q;
        REG_CTRL: rdata_d = ctrl_word(irq_en_q, busy_q, done_q, carry_q);
        default:  rdata_d = result_q;
      endcase
    end
  end

  // State registers; reset clears everything and aborts an in-flight add.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      alive_q   <= 1'b0;
      aw_held_q <= 1'b0;
      awidx_q   <= 2'd0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      irq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      result_q  <= 32'd0;
      vld_p     <= '0;
    end else begin
      alive_q   <= 1'b1;
      aw_held_q <= aw_held_d;
      awidx_q   <= awidx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      irq_en_q  <= irq_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      vld_p[0]  <= start_go;
      for (int i = 1; i < ADD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Add pipeline data: sum formed at START commit, then delayed to completion.
  always_ff @(posedge ACLK) begin
    sum_p[0] <= {1'b0, opa_q} + {1'b0, opb_q};
    for (int i = 1; i < ADD_LATENCY; i++) sum_p[i] <= sum_p[i-1];
  end

endmodule

// File: tb/tb_axil_adder_core.sv
// Directed bench for axil_adder_core: register access, add results,
// handshake back-pressure, DONE/irq behaviour and mid-add reset.
module tb_axil_adder_core;

  localparam int LAT = 4;
  localparam logic [3:0] A_OPA  = 4'h0;
  localparam logic [3:0] A_OPB  = 4'h4;
  localparam logic [3:0] A_CTRL = 4'h8;
  localparam logic [3:0] A_RES  = 4'hC;

  logic ACLK = 1'b0;
  logic ARESET;
  logic irq;
  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  axil_adder_core_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  axil_adder_core #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .ADD_LATENCY(LAT)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .s_axi (bus.slave),
    .irq   (irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write with AW and W together; bounded wait for B (BREADY high).
  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    logic aw_hs, w_hs;
    @(negedge ACLK);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 50) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge ACLK);
      if (aw_hs) bus.S_AXI_AWVALID = 1'b0;
      if (w_hs)  bus.S_AXI_WVALID  = 1'b0;
      n++;
    end
    while (!bus.S_AXI_BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (n >= 50) check("write_timeout", 32'(n), 32'd0);
  endtask

  task automatic read_reg(input logic [3:0] addr, output logic [31:0] data);
    int n;
    logic hs;
    @(negedge ACLK);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    while (bus.S_AXI_ARVALID && n < 50) begin
      hs = bus.S_AXI_ARREADY;
      @(negedge ACLK);
      if (hs) bus.S_AXI_ARVALID = 1'b0;
      n++;
    end
    while (!bus.S_AXI_RVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    data = bus.S_AXI_RDATA;
    @(negedge ACLK);
    bus.S_AXI_ARVALID = 1'b0;
    if (n >= 50) check("read_timeout", 32'(n), 32'd0);
  endtask

  // Scoreboarded read: expectation queued at issue, popped on the R beat.
  task automatic read_chk(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    read_reg(addr, d);
    check(tag_q.pop_front(), d, exp_q.pop_front());
  endtask

  task automatic wait_not_busy(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    read_reg(A_CTRL, d);
    while (d[8] && n < 40) begin
      read_reg(A_CTRL, d);
      n++;
    end
    if (n >= 40) check(tag, 32'(d[8]), 32'd0);
  endtask

  initial begin
    logic [31:0] rexp;
    int n;
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_ready", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd0);
    check("rst_valid_irq", {29'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, irq}, 32'd0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    read_chk(A_CTRL, 32'h0, "rst_ctrl");
    read_chk(A_RES,  32'h0, "rst_result");

    // 1: simple add; OP_B rewritten while busy must not disturb it
    write_reg(A_OPA, 32'd1, 4'hF);
    write_reg(A_OPB, 32'd2, 4'hF);
    write_reg(A_CTRL, 32'h1, 4'hF);
    write_reg(A_OPB, 32'h100, 4'hF);
    wait_not_busy("t1_busy_timeout");
    read_chk(A_RES,  32'h3,   "t1_result");
    read_chk(A_CTRL, 32'h200, "t1_ctrl");
    read_chk(A_OPB,  32'h100, "t1_opb");

    // 2: carry out, with DONE cleared in the START write
    write_reg(A_OPA, 32'hFFFF_FFFF, 4'hF);
    write_reg(A_OPB, 32'h1, 4'hF);
    write_reg(A_CTRL, 32'h201, 4'hF);
    wait_not_busy("t2a_busy_timeout");
    read_chk(A_RES,  32'h0,   "t2a_result");
    read_chk(A_CTRL, 32'h600, "t2a_ctrl");
    write_reg(A_OPA, 32'h8000_0000, 4'hF);
    write_reg(A_OPB, 32'h8000_0000, 4'hF);
    write_reg(A_CTRL, 32'h201, 4'hF);
    wait_not_busy("t2b_busy_timeout");
    read_chk(A_RES,  32'h0,   "t2b_result");
    read_chk(A_CTRL, 32'h600, "t2b_ctrl");

    // 3: byte strobes, RESULT read-only
    write_reg(A_OPA, 32'h0, 4'hF);
    write_reg(A_OPA, 32'hAABB_CCDD, 4'b0010);
    read_chk(A_OPA, 32'h0000_CC00, "t3_strobe");
    write_reg(A_RES, 32'h5, 4'hF);
    read_chk(A_RES, 32'h0, "t3_result_ro");

    // 4: W three cycles ahead of AW, BREADY held low, RREADY held low
    @(negedge ACLK);
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = A_OPB;
    bus.S_AXI_WDATA  = 32'h1234_5678;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_WREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.S_AXI_WVALID = 1'b0;
    check("t4_wready_held", {30'd0, bus.S_AXI_WREADY, bus.S_AXI_AWREADY}, 32'd1);
    repeat (2) @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b1;
    while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 1'b0;
    while (!bus.S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    check("t4_b_arrived", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_b_stall", {28'd0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BRESP == 2'b00}, 32'h9);
      @(negedge ACLK);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("t4_b_done", {29'd0, bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'h3);
    read_chk(A_OPB, 32'h1234_5678, "t4_opb");

    @(negedge ACLK);
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_ARADDR  = A_OPB;
    bus.S_AXI_ARVALID = 1'b1;
    exp_q.push_back(32'h1234_5678);
    tag_q.push_back("t4_r_stall");
    @(negedge ACLK);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    rexp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      check(tag_q[0], bus.S_AXI_RVALID ? bus.S_AXI_RDATA : 32'hDEAD_0000, rexp);
      check("t4_arready_low", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
      @(negedge ACLK);
    end
    void'(tag_q.pop_front());
    bus.S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check("t4_r_done", {31'd0, bus.S_AXI_RVALID}, 32'd0);

    // 5: irq, START while busy ignored, W1C of DONE
    write_reg(A_OPA, 32'd10, 4'hF);
    write_reg(A_OPB, 32'd20, 4'hF);
    write_reg(A_CTRL, 32'h203, 4'hF);
    write_reg(A_CTRL, 32'h003, 4'hF);
    wait_not_busy("t5_busy_timeout");
    read_chk(A_RES,  32'd30,  "t5_result");
    read_chk(A_CTRL, 32'h202, "t5_ctrl_done");
    check("t5_irq_set", {31'd0, irq}, 32'd1);
    write_reg(A_CTRL, 32'h202, 4'hF);
    check("t5_irq_clr", {31'd0, irq}, 32'd0);
    read_chk(A_CTRL, 32'h002, "t5_ctrl_w1c");
    repeat (10) @(negedge ACLK);
    read_chk(A_CTRL, 32'h002, "t5_single_completion");

    // 6: asynchronous reset in the middle of an add
    write_reg(A_OPA, 32'd5, 4'hF);
    write_reg(A_OPB, 32'd6, 4'hF);
    write_reg(A_CTRL, 32'h3, 4'hF);
    check("t6_pre_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    #2 ARESET = 1'b1;
    #1;
    check("t6_async_ready", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd0);
    check("t6_async_out", {29'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID, irq}, 32'd0);
    check("t6_async_rdata", bus.S_AXI_RDATA, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (10) @(negedge ACLK);
    read_chk(A_CTRL, 32'h0, "t6_ctrl");
    read_chk(A_RES,  32'h0, "t6_result");
    read_chk(A_OPA,  32'h0, "t6_opa");
    check("t6_irq", {31'd0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
